// File: rtl/buf_mem_arbiter.sv
// buf_mem_arbiter: three-way round-robin arbiter for the shared buffer port.
// Requesters: 0 = prefetch, 1 = SFTM write, 2 = DPM read.
// Grants are burst-locked until the owner's last beat is accepted.
// Optional feature macro: BUF_ARB_STARVE_BOOST_EN adds per-requester wait
// counters and lets starving requesters win ahead of the round-robin order.
module buf_mem_arbiter #(
  parameter int WAIT_LIMIT = 12,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] req,
  input  logic [2:0] req_last,
  input  logic       mem_ready,
  output logic [2:0] grant,
  output logic [1:0] owner_id,
  output logic       busy,
  output logic       starve_flag
);

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;

  logic       accept_s;
  logic       last_s;
  logic [2:0] cand_s;
  logic [2:0] starve_vec_s;
  logic [2:0] boost_s;
  logic [1:0] win_s;

  // Next index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] nxt3(input logic [1:0] i);
    nxt3 = (i == 2'd2) ? 2'd0 : (i + 2'd1);
  endfunction

  // Round-robin choice: ptr+1 first, then ptr+2, then ptr itself.
  function automatic logic [1:0] rr_pick(input logic [2:0] c, input logic [1:0] ptr);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = nxt3(ptr);
    c2 = nxt3(c1);
    if (c[c1]) begin
      rr_pick = c1;
    end else if (c[c2]) begin
      rr_pick = c2;
    end else begin
      rr_pick = ptr;
    end
  endfunction

  // Fixed priority, lowest index first.
  function automatic logic [1:0] low_pick(input logic [2:0] c);
    if (c[0]) begin
      low_pick = 2'd0;
    end else if (c[1]) begin
      low_pick = 2'd1;
    end else begin
      low_pick = 2'd2;
    end
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [2:0] onehot3(input logic [1:0] i);
    case (i)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  // A beat is taken only from the owner; grant_q is zero outside OWN.
  assign accept_s = (|(req & grant_q)) & mem_ready;
  assign last_s   = accept_s & (|(req_last & grant_q));

  // Candidate set: everyone in ARB, everyone but the owner on a last-beat edge.
  always_comb begin
    cand_s = 3'b000;
    if (enable) begin
      case (state_q)
        ARB: cand_s = req;
        OWN: begin
          if (last_s) begin
            cand_s = req & ~grant_q;
          end else begin
            cand_s = 3'b000;
          end
        end
        default: cand_s = 3'b000;
      endcase
    end else begin
      cand_s = 3'b000;
    end
  end

  // Winner: starving candidates first, otherwise round-robin.
  always_comb begin
    boost_s = cand_s & starve_vec_s;
    if (|boost_s) begin
      win_s = low_pick(boost_s);
    end else begin
      win_s = rr_pick(cand_s, rr_ptr_q);
    end
  end

  // FSM next state and next outputs; grant, owner and busy always move together.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB: begin
        if (|cand_s) begin
          state_d  = OWN;
          grant_d  = onehot3(win_s);
          owner_d  = win_s;
          busy_d   = 1'b1;
          rr_ptr_d = win_s;
        end else begin
          state_d  = ARB;
          grant_d  = 3'b000;
          owner_d  = 2'd0;
          busy_d   = 1'b0;
        end
      end
      OWN: begin
        if (last_s) begin
          if (|cand_s) begin
            state_d  = OWN;
            grant_d  = onehot3(win_s);
            owner_d  = win_s;
            busy_d   = 1'b1;
            rr_ptr_d = win_s;
          end else begin
            state_d  = ARB;
            grant_d  = 3'b000;
            owner_d  = 2'd0;
            busy_d   = 1'b0;
          end
        end else begin
          state_d = OWN;
        end
      end
      default: begin
        state_d = ARB;
        grant_d = 3'b000;
        owner_d = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered grant/owner/busy/round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      grant_q  <= 3'b000;
      owner_q  <= 2'd0;
      busy_q   <= 1'b0;
      rr_ptr_q <= 2'd2;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign busy     = busy_q;

`ifdef BUF_ARB_STARVE_BOOST_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             starve_q, starve_d;

  // Wait counters: count while requesting and not owning, saturate at LIMIT.
  always_comb begin
    starve_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!req[k] || grant_d[k] || grant_q[k]) begin
        cnt_d[k] = {CNT_W{1'b0}};
      end else if (cnt_q[k] != LIMIT) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
      starve_vec_s[k] = (cnt_q[k] == LIMIT);
      starve_d        = starve_d | (cnt_d[k] == LIMIT);
    end
  end

  // Counter and starve flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= {CNT_W{1'b0}};
      end
      starve_q <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      starve_q <= starve_d;
    end
  end

  assign starve_flag = starve_q;
`else
  assign starve_vec_s = 3'b000;
  assign starve_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_buf_mem_arbiter.sv
// Self-checking bench for buf_mem_arbiter: expected grants are queued when
// each cycle's stimulus is driven and popped after the clock edge.
module tb_buf_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] req_last = 3'b000;
  logic       mem_ready = 1'b0;
  logic [2:0] grant;
  logic [1:0] owner_id;
  logic       busy;
  logic       starve_flag;

  logic [2:0] exp_q [$];
  logic       stv_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  buf_mem_arbiter #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .req_last(req_last),
    .mem_ready(mem_ready), .grant(grant), .owner_id(owner_id), .busy(busy),
    .starve_flag(starve_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] idx_of(input logic [2:0] g);
    case (g)
      3'b010:  idx_of = 2'd1;
      3'b100:  idx_of = 2'd2;
      default: idx_of = 2'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; req = 3'b111; req_last = 3'b111; mem_ready = 1'b1;
    repeat (2) tick();
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_cmp++; if (owner_id !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", owner_id); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (starve_flag !== 1'b0) begin n_bad++; $display("FAIL reset_starve: got %b want 0", starve_flag); end
    req = 3'b000; req_last = 3'b000; rst_n = 1'b1;
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_idle: got %b want 000", grant); end
  endtask

  task automatic test_round_robin();
    logic [10:0] tbl [6];
    logic [2:0]  e, g;
    tbl = '{{3'b111,3'b111,1'b1,1'b1,3'b001}, {3'b111,3'b111,1'b1,1'b1,3'b010},
            {3'b111,3'b111,1'b1,1'b1,3'b100}, {3'b111,3'b111,1'b1,1'b1,3'b001},
            {3'b001,3'b001,1'b1,1'b1,3'b000}, {3'b000,3'b000,1'b1,1'b1,3'b000}};
    for (int i = 0; i < 6; i++) begin
      {req, req_last, mem_ready, enable, e} = tbl[i];
      exp_q.push_back(e);
      tick();
      g = exp_q.pop_front();
      n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL rr_grant cyc %0d: got %b want %b", i, grant, g); end
      n_cmp++; if (owner_id !== idx_of(g)) begin n_bad++; $display("FAIL rr_owner cyc %0d: got %0d want %0d", i, owner_id, idx_of(g)); end
      n_cmp++; if (busy !== (|g)) begin n_bad++; $display("FAIL rr_busy cyc %0d: got %b want %b", i, busy, |g); end
    end
  endtask

  task automatic test_burst_ready();
    logic [10:0] tbl [10];
    logic [2:0]  e, g;
    tbl = '{{3'b010,3'b000,1'b1,1'b1,3'b010}, {3'b010,3'b000,1'b1,1'b1,3'b010},
            {3'b010,3'b000,1'b0,1'b1,3'b010}, {3'b011,3'b000,1'b1,1'b1,3'b010},
            {3'b011,3'b000,1'b0,1'b1,3'b010}, {3'b011,3'b001,1'b1,1'b1,3'b010},
            {3'b011,3'b000,1'b0,1'b1,3'b010}, {3'b011,3'b010,1'b1,1'b1,3'b001},
            {3'b001,3'b001,1'b1,1'b1,3'b000}, {3'b000,3'b000,1'b1,1'b1,3'b000}};
    for (int i = 0; i < 10; i++) begin
      {req, req_last, mem_ready, enable, e} = tbl[i];
      exp_q.push_back(e);
      tick();
      g = exp_q.pop_front();
      n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL burst_grant cyc %0d: got %b want %b", i, grant, g); end
      n_cmp++; if (owner_id !== idx_of(g)) begin n_bad++; $display("FAIL burst_owner cyc %0d: got %0d want %0d", i, owner_id, idx_of(g)); end
      n_cmp++; if (busy !== (|g)) begin n_bad++; $display("FAIL burst_busy cyc %0d: got %b want %b", i, busy, |g); end
    end
  endtask

  task automatic test_owner_drop();
    logic [10:0] tbl [8];
    logic [2:0]  e, g;
    tbl = '{{3'b100,3'b000,1'b1,1'b1,3'b100}, {3'b100,3'b000,1'b1,1'b1,3'b100},
            {3'b011,3'b011,1'b1,1'b1,3'b100}, {3'b011,3'b011,1'b1,1'b1,3'b100},
            {3'b011,3'b011,1'b1,1'b1,3'b100}, {3'b111,3'b100,1'b1,1'b1,3'b001},
            {3'b001,3'b001,1'b1,1'b1,3'b000}, {3'b000,3'b000,1'b1,1'b1,3'b000}};
    for (int i = 0; i < 8; i++) begin
      {req, req_last, mem_ready, enable, e} = tbl[i];
      exp_q.push_back(e);
      tick();
      g = exp_q.pop_front();
      n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL drop_grant cyc %0d: got %b want %b", i, grant, g); end
      n_cmp++; if (owner_id !== idx_of(g)) begin n_bad++; $display("FAIL drop_owner cyc %0d: got %0d want %0d", i, owner_id, idx_of(g)); end
      n_cmp++; if (busy !== (|g)) begin n_bad++; $display("FAIL drop_busy cyc %0d: got %b want %b", i, busy, |g); end
    end
  endtask

  task automatic test_enable();
    logic [10:0] tbl [9];
    logic [2:0]  e, g;
    tbl = '{{3'b100,3'b000,1'b1,1'b1,3'b100}, {3'b100,3'b000,1'b1,1'b0,3'b100},
            {3'b111,3'b100,1'b1,1'b0,3'b000}, {3'b011,3'b000,1'b1,1'b0,3'b000},
            {3'b011,3'b000,1'b1,1'b0,3'b000}, {3'b011,3'b000,1'b1,1'b1,3'b001},
            {3'b011,3'b001,1'b1,1'b1,3'b010}, {3'b010,3'b010,1'b1,1'b1,3'b000},
            {3'b000,3'b000,1'b1,1'b1,3'b000}};
    for (int i = 0; i < 9; i++) begin
      {req, req_last, mem_ready, enable, e} = tbl[i];
      exp_q.push_back(e);
      tick();
      g = exp_q.pop_front();
      n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL enable_grant cyc %0d: got %b want %b", i, grant, g); end
      n_cmp++; if (owner_id !== idx_of(g)) begin n_bad++; $display("FAIL enable_owner cyc %0d: got %0d want %0d", i, owner_id, idx_of(g)); end
      n_cmp++; if (busy !== (|g)) begin n_bad++; $display("FAIL enable_busy cyc %0d: got %b want %b", i, busy, |g); end
    end
  endtask

  task automatic test_starve();
    logic [10:0] tbl [14];
    logic [2:0]  e, g;
    logic        s, sp;
    tbl[0] = {3'b010,3'b000,1'b1,1'b1,3'b010};
    for (int i = 1; i < 8; i++) tbl[i] = {3'b011,3'b000,1'b1,1'b1,3'b010};
    tbl[8] = {3'b111,3'b000,1'b1,1'b1,3'b010};
    tbl[9] = {3'b111,3'b000,1'b1,1'b1,3'b010};
`ifdef BUF_ARB_STARVE_BOOST_EN
    tbl[10] = {3'b111,3'b010,1'b1,1'b1,3'b001};
    tbl[11] = {3'b101,3'b001,1'b1,1'b1,3'b100};
    tbl[12] = {3'b100,3'b100,1'b1,1'b1,3'b000};
`else
    tbl[10] = {3'b111,3'b010,1'b1,1'b1,3'b100};
    tbl[11] = {3'b101,3'b100,1'b1,1'b1,3'b001};
    tbl[12] = {3'b001,3'b001,1'b1,1'b1,3'b000};
`endif
    tbl[13] = {3'b000,3'b000,1'b1,1'b1,3'b000};
    for (int i = 0; i < 14; i++) begin
      {req, req_last, mem_ready, enable, e} = tbl[i];
`ifdef BUF_ARB_STARVE_BOOST_EN
      s = (i >= 4) && (i <= 9);
`else
      s = 1'b0;
`endif
      exp_q.push_back(e);
      stv_q.push_back(s);
      tick();
      g  = exp_q.pop_front();
      sp = stv_q.pop_front();
      n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL starve_grant cyc %0d: got %b want %b", i, grant, g); end
      n_cmp++; if (owner_id !== idx_of(g)) begin n_bad++; $display("FAIL starve_owner cyc %0d: got %0d want %0d", i, owner_id, idx_of(g)); end
      n_cmp++; if (starve_flag !== sp) begin n_bad++; $display("FAIL starve_flag cyc %0d: got %b want %b", i, starve_flag, sp); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] g;
    enable = 1'b1; req = 3'b100; req_last = 3'b000; mem_ready = 1'b1;
    exp_q.push_back(3'b100);
    tick();
    tick();
    g = exp_q.pop_front();
    n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL mid_pre_grant: got %b want %b", grant, g); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL mid_async_grant: got %b want 000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    n_cmp++; if (owner_id !== 2'd0) begin n_bad++; $display("FAIL mid_async_owner: got %0d want 0", owner_id); end
    n_cmp++; if (starve_flag !== 1'b0) begin n_bad++; $display("FAIL mid_async_starve: got %b want 0", starve_flag); end
    req = 3'b110;
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL mid_held_grant: got %b want 000", grant); end
    rst_n = 1'b1;
    exp_q.push_back(3'b010);
    tick();
    g = exp_q.pop_front();
    n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL mid_first_grant: got %b want %b", grant, g); end
    n_cmp++; if (owner_id !== idx_of(g)) begin n_bad++; $display("FAIL mid_first_owner: got %0d want %0d", owner_id, idx_of(g)); end
    req = 3'b010; req_last = 3'b010;
    exp_q.push_back(3'b000);
    tick();
    g = exp_q.pop_front();
    n_cmp++; if (grant !== g) begin n_bad++; $display("FAIL mid_end_grant: got %b want %b", grant, g); end
    req = 3'b000; req_last = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_ready();
    test_owner_drop();
    test_enable();
    test_starve();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buf_mem_arbiter.md
BUF_MEM_ARBITER -- requirements
Module: buf_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 12: wait-cycle count at which a requester is treated as starving (range 2..15).
REQ-002 SHALL have parameter CNT_W, default 4: width of the per-requester wait counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  permits new grants; driven by the global controller.
REQ-006 SHALL have port req  input  3  per-requester request, indexed 0=prefetch, 1=SFTM write, 2=DPM read.
REQ-007 SHALL have port req_last  input  3  per-requester end-of-burst marker, qualified by the matching req bit.
REQ-008 SHALL have port mem_ready  input  1  the shared buffer port accepts a beat this cycle.
REQ-009 SHALL have port grant  output  3  registered one-hot (or zero) grant.
REQ-010 SHALL have port owner_id  output  2  index of the granted requester; 0 when none is granted.
REQ-011 SHALL have port busy  output  1  high while grant is non-zero.
REQ-012 SHALL have port starve_flag  output  1  high while any wait counter equals WAIT_LIMIT.

Function
REQ-013 SHALL implement a two-state FSM:
- ARB: grant = 0.
- OWN: exactly one grant bit is set.
REQ-014 In ARB, with enable=1 and req non-zero, the block SHALL select a winner and register the grant, entering OWN on the next edge (1-cycle request-to-grant latency).
REQ-015 Winner selection SHALL be round-robin from rr_ptr: candidate order (rr_ptr+1), (rr_ptr+2), (rr_ptr+3), all mod 3. rr_ptr updates to the winner index on each grant.
REQ-016 A beat SHALL be counted as accepted when the owner's req bit and mem_ready are both high in the same cycle.
REQ-017 Grants SHALL be burst-locked: grant holds until a beat is accepted with req_last[owner]=1, even if the owner's req drops mid-burst.
REQ-018 On a last-beat edge, if enable=1 and any other request is pending (the owner's own bit is excluded), a new winner SHALL be granted on that same edge with no idle cycle; otherwise the FSM SHALL return to ARB.
REQ-019 The owner SHALL NOT be re-granted back-to-back while another requester is pending; if it is the sole requester, it SHALL be re-granted one cycle after returning to ARB.
REQ-020 With enable=0, the current burst SHALL complete normally; no new grant SHALL be issued.
REQ-021 A req bit set for a non-owner SHALL be ignored until re-arbitration; req_last on a non-owner SHALL be ignored.
REQ-022 If mem_ready=0, the grant SHALL hold and no beat SHALL be counted.
REQ-023 owner_id and busy SHALL be registered together with grant, so all three are consistent in every cycle.

Reset
REQ-024 On rst_n=0 the block SHALL, asynchronously and regardless of current state or burst progress:
- set grant=0, owner_id=0, busy=0, starve_flag=0;
- set the FSM to ARB, rr_ptr=2 (requester 0 wins first), and all wait counters to 0.
REQ-025 After reset release, the first grant SHALL occur no earlier than one edge after a request is seen.

Configuration
REQ-026 With macro BUF_ARB_STARVE_BOOST_EN defined, the block SHALL include one CNT_W-bit wait counter per requester:
- each counter increments every cycle its req is high and it is not the owner, saturating at WAIT_LIMIT;
- a counter clears when its requester is granted or its req is low.
REQ-027 With BUF_ARB_STARVE_BOOST_EN defined, any requester whose counter equals WAIT_LIMIT SHALL win the next arbitration ahead of the round-robin order (lowest index first among starving requesters), and rr_ptr SHALL still update to the winner.
REQ-028 Without BUF_ARB_STARVE_BOOST_EN, the wait counters SHALL be absent, arbitration SHALL be pure round-robin, and starve_flag SHALL be constant 0.

Verification
REQ-029 Reset, then req=3'b111 held, mem_ready=1, req_last=3'b111 -> grants one cycle after req: 001, 010, 100, 001, each lasting one cycle, with no gaps.
REQ-030 req[1] with a 4-beat burst (req_last on beat 4), mem_ready toggling 1,0,1,0,… -> grant=010 is held for 7 cycles; req[0] raised mid-burst is granted on the edge where beat 4 is accepted.
REQ-031 Owner drops req for 3 cycles mid-burst -> grant stays unchanged, busy=1, and no other requester is granted.
REQ-032 enable falls during req[2]'s burst -> the burst completes, then grant=0 while enable=0 even with req=3'b011 pending; the first grant follows 1 cycle after enable rises.
REQ-033 BUF_ARB_STARVE_BOOST_EN defined, WAIT_LIMIT=4, requester 1 bursts 10 beats while req[0] is held -> starve_flag rises after 4 waiting cycles; requester 0 wins over requester 2 at the next arbitration.
REQ-034 rst_n asserted mid-burst with grant=100 -> grant=0, busy=0, starve_flag=0 immediately; after release with req=3'b110, the first grant is 010.
